// File: rtl/tennis_score_keeper.sv
// Tennis game/set scorer feeding the eight-digit seven-segment driver (AN_In/C_In).
// Optional macro BLINK_EN: blink the winner's games digit once the set is over.
module tennis_score_keeper #(
  parameter int unsigned GAMES_TO_WIN = 6,
  parameter int unsigned BLINK_DIV    = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        point1,
  input  logic        point2,
  output logic [7:0]  AN_In,
  output logic [55:0] C_In,
  output logic        match_over,
  output logic [1:0]  winner
);

  localparam int unsigned GAME_W = 4;
  localparam int unsigned PTS_W  = 2;
  localparam int unsigned SEG_W  = 7;
  localparam logic [GAME_W-1:0] GAMES_TGT = GAME_W'(GAMES_TO_WIN);

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;

  if ((GAMES_TO_WIN < 1) || (GAMES_TO_WIN > 9) || (BLINK_DIV < 1)) begin : g_param_check
    $error("tennis_score_keeper: GAMES_TO_WIN must be 1..9 and BLINK_DIV >= 1");
  end

  typedef enum logic [2:0] {
    ST_PLAY  = 3'd0,
    ST_DEUCE = 3'd1,
    ST_ADV1  = 3'd2,
    ST_ADV2  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PTS_W-1:0]    p1_pts_q, p1_pts_d, p2_pts_q, p2_pts_d;
  logic [GAME_W-1:0]   games1_q, games1_d, games2_q, games2_d;
  logic                point1_q, point2_q;
  logic                p1_hit, p2_hit, hit1, hit2, win1, win2;
  logic                blink_on;
  logic [7:0]          an_d;
  logic [55:0]         c_d;
  logic [1:0]          winner_d;

  function automatic logic [SEG_W-1:0] seg_digit(input logic [GAME_W-1:0] d);
    case (d)
      4'd0:    seg_digit = 7'b0111111;
      4'd1:    seg_digit = 7'b0000110;
      4'd2:    seg_digit = 7'b1011011;
      4'd3:    seg_digit = 7'b1001111;
      4'd4:    seg_digit = 7'b1100110;
      4'd5:    seg_digit = 7'b1101101;
      4'd6:    seg_digit = 7'b1111100;
      4'd7:    seg_digit = 7'b0100111;
      4'd8:    seg_digit = 7'b1111111;
      4'd9:    seg_digit = 7'b1100111;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  // One player's two-digit point field: {en_tens, en_units, seg_tens, seg_units}.
  function automatic logic [15:0] pair_render(input state_e st, input logic [PTS_W-1:0] pts,
                                              input logic is_p1);
    logic [1:0]       en;
    logic [SEG_W-1:0] t;
    logic [SEG_W-1:0] u;
    en = 2'b00;
    t  = SEG_BLANK;
    u  = SEG_BLANK;
    case (st)
      ST_PLAY: begin
        case (pts)
          2'd0: begin en = 2'b01; u = seg_digit(4'd0); end
          2'd1: begin en = 2'b11; t = seg_digit(4'd1); u = seg_digit(4'd5); end
          2'd2: begin en = 2'b11; t = seg_digit(4'd3); u = seg_digit(4'd0); end
          default: begin en = 2'b11; t = seg_digit(4'd4); u = seg_digit(4'd0); end
        endcase
      end
      ST_DEUCE: begin en = 2'b11; t = seg_digit(4'd4); u = seg_digit(4'd0); end
      ST_ADV1:  if (is_p1)  begin en = 2'b11; t = SEG_A; u = SEG_D; end
      ST_ADV2:  if (!is_p1) begin en = 2'b11; t = SEG_A; u = SEG_D; end
      default: ;
    endcase
    return {en, t, u};
  endfunction

  // Rising-edge detect; simultaneous presses cancel each other.
  assign p1_hit = point1 & ~point1_q;
  assign p2_hit = point2 & ~point2_q;
  assign hit1   = p1_hit & ~p2_hit;
  assign hit2   = p2_hit & ~p1_hit;

  always_comb begin
    state_d  = state_q;
    p1_pts_d = p1_pts_q;
    p2_pts_d = p2_pts_q;
    games1_d = games1_q;
    games2_d = games2_q;
    win1     = 1'b0;
    win2     = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (hit1) begin
          if (p1_pts_q == 2'd3)                          win1 = 1'b1;
          else if (p1_pts_q == 2'd2 && p2_pts_q == 2'd3) state_d = ST_DEUCE;
          else                                           p1_pts_d = p1_pts_q + 2'd1;
        end else if (hit2) begin
          if (p2_pts_q == 2'd3)                          win2 = 1'b1;
          else if (p2_pts_q == 2'd2 && p1_pts_q == 2'd3) state_d = ST_DEUCE;
          else                                           p2_pts_d = p2_pts_q + 2'd1;
        end
      end
      ST_DEUCE: begin
        if (hit1)      state_d = ST_ADV1;
        else if (hit2) state_d = ST_ADV2;
      end
      ST_ADV1: begin
        if (hit1)      win1 = 1'b1;
        else if (hit2) state_d = ST_DEUCE;
      end
      ST_ADV2: begin
        if (hit2)      win2 = 1'b1;
        else if (hit1) state_d = ST_DEUCE;
      end
      default: ;
    endcase
    if (win1) begin
      games1_d = games1_q + 4'd1;
      p1_pts_d = '0;
      p2_pts_d = '0;
      state_d  = (games1_d == GAMES_TGT) ? ST_DONE : ST_PLAY;
    end
    if (win2) begin
      games2_d = games2_q + 4'd1;
      p1_pts_d = '0;
      p2_pts_d = '0;
      state_d  = (games2_d == GAMES_TGT) ? ST_DONE : ST_PLAY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_PLAY;
      p1_pts_q <= '0;
      p2_pts_q <= '0;
      games1_q <= '0;
      games2_q <= '0;
      point1_q <= 1'b0;
      point2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_pts_q <= p1_pts_d;
      p2_pts_q <= p2_pts_d;
      games1_q <= games1_d;
      games2_q <= games2_d;
      point1_q <= point1;
      point2_q <= point2;
    end
  end

`ifdef BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;

  // Free-running blink phase, lit out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BLINK_W'(1);
    end
  end
  assign blink_on = blink_phase_q;
`else
  assign blink_on = 1'b1;
`endif

  always_comb begin
    logic [15:0] p1r;
    logic [15:0] p2r;
    logic        done;
    logic        g1_en;
    logic        g2_en;
    done     = (state_q == ST_DONE);
    p1r      = pair_render(state_q, p1_pts_q, 1'b1);
    p2r      = pair_render(state_q, p2_pts_q, 1'b0);
    g1_en    = !(done && games1_q == GAMES_TGT) || blink_on;
    g2_en    = !(done && games2_q == GAMES_TGT) || blink_on;
    an_d     = {p1r[15:14], g1_en, 1'b0, g2_en, 1'b0, p2r[15:14]};
    c_d      = {p1r[13:0], seg_digit(games1_q), SEG_BLANK, seg_digit(games2_q), SEG_BLANK, p2r[13:0]};
    winner_d = !done ? 2'b00 : ((games1_q == GAMES_TGT) ? 2'b01 : 2'b10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN_In      <= 8'h00;
      C_In       <= 56'h0;
      match_over <= 1'b0;
      winner     <= 2'b00;
    end else begin
      AN_In      <= an_d;
      C_In       <= c_d;
      match_over <= (state_q == ST_DONE);
      winner     <= winner_d;
    end
  end

endmodule

// File: tb/tb_tennis_score_keeper.sv
// Scoreboard bench for tennis_score_keeper: a point-count tennis model predicts the display.
module tb_tennis_score_keeper;

  localparam int G = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        point1, point2;
  logic [7:0]  AN_In;
  logic [55:0] C_In;
  logic        match_over;
  logic [1:0]  winner;

  tennis_score_keeper #(.GAMES_TO_WIN(G), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .point1(point1), .point2(point2),
    .AN_In(AN_In), .C_In(C_In), .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  an;
    logic [55:0] c;
    logic        mo;
    logic [1:0]  win;
    int          due;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: raw points won in the current game, games won, set over.
  int pa, pb, g1, g2;
  bit done, prev1, prev2;

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111100;
      7: return 7'b0100111;
      8: return 7'b1111111;
      9: return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [15:0] score_pair(int n);
    int sc;
    logic [6:0] t;
    case (n)
      0: sc = 0;
      1: sc = 15;
      2: sc = 30;
      default: sc = 40;
    endcase
    t = (sc >= 10) ? seg_of(sc / 10) : 7'd0;
    return {(sc >= 10), 1'b1, t, seg_of(sc % 10)};
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [15:0] p1r, p2r;
    p1r = '0;
    p2r = '0;
    if (!done) begin
      if (pa >= 3 && pb >= 3) begin
        if (pa == pb) begin
          p1r = score_pair(3);
          p2r = score_pair(3);
        end else if (pa > pb) p1r = {2'b11, 7'b1110111, 7'b1011110};
        else                  p2r = {2'b11, 7'b1110111, 7'b1011110};
      end else begin
        p1r = score_pair(pa);
        p2r = score_pair(pb);
      end
    end
    e.an  = {p1r[15:14], 1'b1, 1'b0, 1'b1, 1'b0, p2r[15:14]};
    e.c   = {p1r[13:0], seg_of(g1), 7'd0, seg_of(g2), 7'd0, p2r[13:0]};
    e.mo  = done;
    e.win = !done ? 2'b00 : ((g1 >= G) ? 2'b01 : 2'b10);
    e.due = 0;
    return e;
  endfunction

  task automatic award(input bit to_p1);
    if (to_p1) pa++; else pb++;
    if (pa >= 4 && pa >= pb + 2) begin
      g1++; pa = 0; pb = 0;
      if (g1 == G) done = 1'b1;
    end else if (pb >= 4 && pb >= pa + 2) begin
      g2++; pa = 0; pb = 0;
      if (g2 == G) done = 1'b1;
    end else if (pa == pb && pa > 3) begin
      pa = 3; pb = 3;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare DUT outputs against the expectation due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      tests++;
      fails++;
      $display("FAIL stale_expect: due %0d, now cycle %0d", q[0].due, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("AN_In", 64'(AN_In), 64'(e.an));
      chk("C_In", 64'(C_In), 64'(e.c));
      chk("match_winner", 64'({match_over, winner}), 64'({e.mo, e.win}));
    end
  end

  // Drive one cycle of levels; the display reflects it two edges later.
  task automatic step(input bit a, input bit b);
    exp_t e;
    bit h1, h2;
    point1 = a;
    point2 = b;
    h1 = a & ~prev1;
    h2 = b & ~prev2;
    prev1 = a;
    prev2 = b;
    if (!done && h1 && !h2) award(1'b1);
    else if (!done && h2 && !h1) award(1'b0);
    e = expect_now();
    e.due = cyc + 2;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit to_p1);
    step(to_p1, !to_p1);
    step(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_AN"}, 64'(AN_In), 64'h0);
    chk({tag, "_C"}, 64'(C_In), 64'h0);
    chk({tag, "_mw"}, 64'({match_over, winner}), 64'h0);
  endtask

  task automatic model_reset();
    pa = 0; pb = 0; g1 = 0; g2 = 0;
    done = 1'b0; prev1 = 1'b0; prev2 = 1'b0;
  endtask

  // Assert reset between edges, confirm immediate clear, then release after an edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    point1 = 1'b0;
    point2 = 1'b0;
    q.delete();
    #1;
    check_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    point1 = 1'b0;
    point2 = 1'b0;
    model_reset();
    #1;
    check_zero("rst_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    for (int i = 0; i < 3; i++) pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);

    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    async_reset();
    for (int i = 0; i < 4 * G; i++) pulse(1'b1);
    for (int i = 0; i < 6; i++) pulse(i[0]);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    pulse(1'b0);
    pulse(1'b1);
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int stop_at;
      stop_at = (r == 1) ? int'($urandom_range(100, 600)) : -1;
      for (int i = 0; i < 1200; i++) begin
        bit a, b;
        if (i == stop_at) async_reset();
        a = ($urandom_range(0, 3) < (r == 2 ? 3 : 2));
        b = ($urandom_range(0, 1) == 1);
        step(a, b);
      end
      async_reset();
    end

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations unchecked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
